least_strip_tree: RTL

Parametrised, fully pipelined minimum-width selector for the strip-packing datapath. It takes NUM_STRIPS strip candidates per cycle and returns the eligible strip with the smallest width. Eligibility comes from a per-strip mask and an optional fit test against a requested width. It supersedes the fixed 3-input selector, sits between the strip-width register file and the placement controller, and accepts one request per cycle with a fixed, parameter-derived latency.

---
 rtl/least_strip_tree.sv | 129 ++++++++++++
 1 files changed

// File: rtl/least_strip_tree.sv
// Pipelined minimum-width strip selector: stage-0 eligibility, a registered
// binary comparator tree, and an output register that holds between results.
module least_strip_tree #(
    parameter int NUM_STRIPS = 8,
    parameter int ID_W       = 4,
    parameter int WIDTH_W    = 8,
    parameter int MAX_WIDTH  = 128,
    localparam int IDX_W     = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          valid_i,
    input  logic [NUM_STRIPS*ID_W-1:0]    strip_id_i,
    input  logic [NUM_STRIPS*WIDTH_W-1:0] strip_width_i,
    input  logic [NUM_STRIPS-1:0]         strip_mask_i,
    input  logic                          fit_mode_i,
    input  logic [WIDTH_W-1:0]            req_width_i,
    output logic                          valid_o,
    output logic                          found_o,
    output logic [ID_W-1:0]               strip_id_o,
    output logic [WIDTH_W-1:0]            strip_width_o,
    output logic [IDX_W-1:0]              strip_idx_o
);

    localparam int LEVELS     = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 0;
    localparam int LEAVES     = 1 << LEVELS;
    localparam int NODES      = 2 * LEAVES - 1;
    localparam int FIRST_LEAF = LEAVES - 1;
    localparam logic [WIDTH_W:0]   MAX_SUM = (WIDTH_W + 1)'(MAX_WIDTH);
    localparam logic [WIDTH_W-1:0] MAX_OUT = WIDTH_W'(MAX_WIDTH);

    // Right wins only when it is eligible and strictly narrower (or left is ineligible).
    function automatic logic take_right(input logic l_elig, input logic [WIDTH_W-1:0] l_width,
                                        input logic r_elig, input logic [WIDTH_W-1:0] r_width);
        return r_elig & (~l_elig | (r_width < l_width));
    endfunction

    logic [LEVELS:0]    valid_r;
    logic               leaf_elig_s  [LEAVES];
    logic [WIDTH_W-1:0] leaf_width_s [LEAVES];
    logic [ID_W-1:0]    leaf_id_s    [LEAVES];
    // Heap layout: node 0 is the root, children of node i are 2i+1 (left) and 2i+2 (right).
    logic               node_elig_r  [NODES];
    logic [WIDTH_W-1:0] node_width_r [NODES];
    logic [ID_W-1:0]    node_id_r    [NODES];
    logic [IDX_W-1:0]   node_idx_r   [NODES];

    // Leaf values: padding leaves first, then real candidates with mask and fit test.
    always_comb begin
        for (int k = 0; k < LEAVES; k++) begin
            leaf_elig_s[k]  = 1'b0;
            leaf_width_s[k] = {WIDTH_W{1'b0}};
            leaf_id_s[k]    = {ID_W{1'b0}};
        end
        for (int k = 0; k < NUM_STRIPS; k++) begin
            leaf_width_s[k] = strip_width_i[k*WIDTH_W +: WIDTH_W];
            leaf_id_s[k]    = strip_id_i[k*ID_W +: ID_W];
            if (fit_mode_i) begin
                leaf_elig_s[k] = strip_mask_i[k] &
                    (({1'b0, leaf_width_s[k]} + {1'b0, req_width_i}) <= MAX_SUM);
            end else begin
                leaf_elig_s[k] = strip_mask_i[k];
            end
        end
    end

    // Per-stage valid bits; reset drops everything in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_r <= {(LEVELS + 1){1'b0}};
        end else begin
            valid_r[0] <= valid_i;
            for (int j = 1; j <= LEVELS; j++) begin
                valid_r[j] <= valid_r[j-1];
            end
        end
    end

    // Data pipeline: stage-0 leaves and every tree node load each cycle.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < LEAVES; k++) begin
            node_elig_r[FIRST_LEAF+k]  <= leaf_elig_s[k];
            node_width_r[FIRST_LEAF+k] <= leaf_width_s[k];
            node_id_r[FIRST_LEAF+k]    <= leaf_id_s[k];
            node_idx_r[FIRST_LEAF+k]   <= IDX_W'(k);
        end
        for (int i = 0; i < LEAVES - 1; i++) begin
            if (take_right(node_elig_r[2*i+1], node_width_r[2*i+1],
                           node_elig_r[2*i+2], node_width_r[2*i+2])) begin
                node_elig_r[i]  <= node_elig_r[2*i+2];
                node_width_r[i] <= node_width_r[2*i+2];
                node_id_r[i]    <= node_id_r[2*i+2];
                node_idx_r[i]   <= node_idx_r[2*i+2];
            end else begin
                node_elig_r[i]  <= node_elig_r[2*i+1];
                node_width_r[i] <= node_width_r[2*i+1];
                node_id_r[i]    <= node_id_r[2*i+1];
                node_idx_r[i]   <= node_idx_r[2*i+1];
            end
        end
    end

    // Output register: loads on a final-stage valid, otherwise holds the last result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o       <= 1'b0;
            found_o       <= 1'b0;
            strip_id_o    <= {ID_W{1'b0}};
            strip_width_o <= MAX_OUT;
            strip_idx_o   <= {IDX_W{1'b0}};
        end else begin
            valid_o <= valid_r[LEVELS];
            if (valid_r[LEVELS]) begin
                if (node_elig_r[0]) begin
                    found_o       <= 1'b1;
                    strip_id_o    <= node_id_r[0];
                    strip_width_o <= node_width_r[0];
                    strip_idx_o   <= node_idx_r[0];
                end else begin
                    found_o       <= 1'b0;
                    strip_id_o    <= {ID_W{1'b0}};
                    strip_width_o <= MAX_OUT;
                    strip_idx_o   <= {IDX_W{1'b0}};
                end
            end
        end
    end

endmodule
